pipe_stage: RTL

//  - Generic, parametrised inter-stage pipeline register for the RISC-V core.
//  - Successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Carries an opaque WIDTH-bit payload (PC, instr, control bundle, results) with valid/ready handshake,

---
 rtl/pipe_pkg.sv | 52 +++++
 rtl/pipe_slot.sv | 26 ++
 rtl/pipe_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the inter-stage pipeline registers.
//   pipe_state_e   occupancy state of a pipe_stage (value = beats held)
//   if_id_t .. mem_wb_t   per-stage payload bundles; instantiate pipe_stage
//                         with WIDTH = $bits(<bundle>) and pack/unpack around it.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  aluOp;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  rd;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wbData;
        logic [4:0]  rd;
        logic        regWrite;
    } mem_wb_t;

    // The state encoding doubles as the beat count.
    function automatic logic [1:0] stateOccupancy(input pipe_state_e s);
        return logic'(s == FULL) ? 2'd2 : (s == BUSY) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one WIDTH-bit payload register.
//   clk   in  stage clock
//   clear in  synchronous clear to RST_PAYLOAD (has priority over load)
//   load  in  capture d on this edge
//   d     in  next payload
//   q     out held payload
module pipe_slot #(
    parameter int              WIDTH       = 32,
    parameter logic [WIDTH-1:0] RST_PAYLOAD = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= RST_PAYLOAD;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: parametrised inter-stage pipeline register with a 1-entry skid
// buffer, flush, and registered in_ready.
//   clk, rst (sync, active-high), flush (kills all held beats)
//   in_valid / in_ready / in_data     upstream side
//   out_valid / out_ready / out_data  downstream side
//   occupancy  beats held (0..2)
//   dbgState   current FSM state, for checkers
//   stall_cnt / bubble_cnt  present only when PIPE_STAGE_PERF_EN is defined
//
// Handshake: a beat moves when valid & ready are both high at a rising edge.
// A producer holding valid may not rely on ready to change its data until the
// beat moves; ready never depends combinationally on valid in this block.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RST_PAYLOAD = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output pipe_state_e      dbgState
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      bubble_cnt
`endif
);

    pipe_state_e      state;
    logic             inReadyReg;
    logic             inFire;
    logic             outFire;
    logic             slotClear;
    logic             outLoad;
    logic             skidLoad;
    logic [WIDTH-1:0] outD;
    logic [WIDTH-1:0] skidQ;

    // inReadyReg always equals (state != FULL); it is held at 1 through reset
    // so the stage is ready on the first cycle rst is low, and rst masks it.
    assign in_ready  = inReadyReg & ~rst;
    assign out_valid = (state != EMPTY);
    assign inFire    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready;
    assign occupancy = stateOccupancy(state);
    assign dbgState  = state;

    assign slotClear = rst | flush;
    // Out reg takes a new beat when it is free or being emptied; from FULL it
    // takes the skid beat so order is preserved.
    assign outLoad   = (inFire & ((state == EMPTY) | ((state == BUSY) & outFire)))
                     | ((state == FULL) & outFire);
    assign outD      = (state == FULL) ? skidQ : in_data;
    assign skidLoad  = inFire & (state == BUSY) & ~outFire;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= EMPTY;
            inReadyReg <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (inFire) state <= BUSY;
                end
                BUSY: begin
                    if (inFire && !outFire) begin
                        state      <= FULL;
                        inReadyReg <= 1'b0;
                    end else if (!inFire && outFire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (outFire) begin
                        state      <= BUSY;
                        inReadyReg <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    inReadyReg <= 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(.WIDTH(WIDTH), .RST_PAYLOAD(RST_PAYLOAD)) outSlot (
        .clk   (clk),
        .clear (slotClear),
        .load  (outLoad),
        .d     (outD),
        .q     (out_data)
    );

    pipe_slot #(.WIDTH(WIDTH), .RST_PAYLOAD(RST_PAYLOAD)) skidSlot (
        .clk   (clk),
        .clear (slotClear),
        .load  (skidLoad),
        .d     (in_data),
        .q     (skidQ)
    );

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != PERF_CNT_MAX)
                stall_cnt <= stall_cnt + 32'd1;
            if (!out_valid && bubble_cnt != PERF_CNT_MAX)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
